// File: rtl/quant_coeff_writer_pkg.sv
// Shared types and bit positions for the coefficient RAM writer.
package quant_coeff_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int BUSY_BIT = 0;
  localparam int DONE_BIT = 1;
  localparam int OVR_BIT  = 2;

  localparam int TRIG_BIT = 0;
  localparam int RAMP_BIT = 1;
  localparam int LEN_LSB  = 8;
  localparam int LEN_MSB  = 15;

  localparam int CNT_W    = 16;

endpackage

// File: rtl/quant_coeff_writer_ctrl_edge_sync.sv
// Brings the software trigger bit into the local clock domain and flags its rising edge.
module ctrl_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_in,
  output logic trig_evt
);

  logic       s1_q, s2_q, s3_q;
  logic       s3_d;
  logic [1:0] warm_q, warm_d;

  // The history flop samples the raw input once after reset and holds it until
  // the synchroniser has filled, so a level already high out of reset is not an edge.
  always_comb begin
    warm_d = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    case (warm_q)
      2'd0:    s3_d = trig_in;
      2'd1:    s3_d = s3_q;
      default: s3_d = s2_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      warm_q <= 2'd0;
    end else begin
      s1_q   <= trig_in;
      s2_q   <= s1_q;
      s3_q   <= s3_d;
      warm_q <= warm_d;
    end
  end

  assign trig_evt = s2_q & ~s3_q;

endmodule

// File: rtl/quant_coeff_writer.sv
// Writes a software-described burst of coefficient words into a RAM, one per cycle.
module quant_coeff_writer
  import quant_coeff_writer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       reg_addr,
  input  logic [31:0]       reg_data,
  input  logic [31:0]       reg_ctrl,
  output logic              coeff_we,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic [DATA_W-1:0] coeff_data,
  output logic [31:0]       status
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        rem_q, rem_d;
  logic              ramp_q, ramp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trig_evt;

  ctrl_edge_sync u_sync (
    .clk      (user_clk),
    .rst_n    (user_rst_n),
    .trig_in  (reg_ctrl[TRIG_BIT]),
    .trig_evt (trig_evt)
  );

  // The first word is loaded together with the IDLE->WRITE step so coeff_we rises
  // in the same cycle the FSM enters WRITE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rem_d   = rem_q;
    ramp_d  = ramp_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (trig_evt) begin
          state_d = WRITE;
          we_d    = 1'b1;
          addr_d  = reg_addr[ADDR_W-1:0];
          data_d  = reg_data[DATA_W-1:0];
          rem_d   = reg_ctrl[LEN_MSB:LEN_LSB];
          ramp_d  = reg_ctrl[RAMP_BIT];
          busy_d  = 1'b1;
          done_d  = 1'b0;
          ovr_d   = 1'b0;
        end
      end
      WRITE: begin
        addr_d = addr_q + 1'b1;
        if (ramp_q) data_d = data_q + 1'b1;
        if (rem_q == 8'd0) begin
          state_d = DONE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - 8'd1;
        end
        if (trig_evt) ovr_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if (trig_evt) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (we_q && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      ramp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      ramp_q  <= ramp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign coeff_we   = we_q;
  assign coeff_addr = addr_q;
  assign coeff_data = data_q;

  always_comb begin
    status           = '0;
    status[BUSY_BIT] = busy_q;
    status[DONE_BIT] = done_q;
    status[OVR_BIT]  = ovr_q;
    status[31:16]    = cnt_q;
  end

  // Address/data bits above the configured widths and unused control bits.
  logic unused_inputs;
  assign unused_inputs = ^{reg_addr, reg_data, reg_ctrl};

endmodule

// File: tb/tb_quant_coeff_writer.sv
// Bench for quant_coeff_writer: vector table of bursts plus hand-written corner sequences.
module tb_quant_coeff_writer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       reg_addr, reg_data, reg_ctrl;
  logic              coeff_we;
  logic [ADDR_W-1:0] coeff_addr;
  logic [DATA_W-1:0] coeff_data;
  logic [31:0]       status;

  quant_coeff_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .reg_addr   (reg_addr),
    .reg_data   (reg_data),
    .reg_ctrl   (reg_ctrl),
    .coeff_we   (coeff_we),
    .coeff_addr (coeff_addr),
    .coeff_data (coeff_data),
    .status     (status)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    bit                rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [7:0]        len;
    bit                ramp;
    int                exp_wr;
    logic [15:0]       exp_cnt;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   tests = 0;
  int   fails = 0;
  int   n_wr  = 0;
  int   cyc   = 0;
  int   first_we_cyc = -1;
  logic we_prev = 1'b0;

  always @(posedge user_clk) cyc++;

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge user_clk) begin
    if (coeff_we === 1'b1) begin
      n_wr++;
      if (!we_prev) first_we_cyc = cyc;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h", coeff_addr, coeff_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.addr !== coeff_addr || mon_e.data !== coeff_data) begin
          fails++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   coeff_addr, coeff_data, mon_e.addr, mon_e.data);
        end
      end
    end
    we_prev = coeff_we;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int len, input bit ramp);
    wr_t w;
    for (int i = 0; i <= len; i++) begin
      w.addr = ADDR_W'(a + i);
      w.data = ramp ? DATA_W'(d + i) : d;
      exp_q.push_back(w);
    end
  endtask

  task automatic trig(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [7:0] len, input bit ramp);
    @(negedge user_clk);
    reg_addr = 32'(a);
    reg_data = 32'(d);
    reg_ctrl = {16'h0, len, 6'h0, ramp, 1'b0};
    @(negedge user_clk);
    reg_ctrl[0] = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge user_clk);
      if (status[0]) begin ok = 1'b1; break; end
    end
    chk({name, "_busy_seen"}, 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge user_clk);
      if (!status[0]) begin ok = 1'b1; break; end
    end
    chk({name, "_busy_clear"}, 32'(ok), 32'd1);
  endtask

  task automatic release_trig();
    @(negedge user_clk);
    reg_ctrl[0] = 1'b0;
    repeat (4) @(negedge user_clk);
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_rst_n = 1'b0;
    repeat (2) @(negedge user_clk);
    exp_q.delete();
    user_rst_n = 1'b1;
    repeat (2) @(negedge user_clk);
  endtask

  vec_t vecs[4];

  initial begin
    int n0, n1, c0;
    vecs[0] = '{1'b1, 10'h005, 32'hDEADBEEF, 8'd0, 1'b0, 1, 16'd1};
    vecs[1] = '{1'b1, 10'h3FE, 32'h00000007, 8'd3, 1'b1, 4, 16'd4};
    vecs[2] = '{1'b0, 10'h100, 32'hFFFFFFFE, 8'd3, 1'b1, 4, 16'd8};
    vecs[3] = '{1'b0, 10'h3F0, 32'h0000A5A5, 8'd7, 1'b0, 8, 16'd16};

    user_rst_n = 1'b0;
    reg_addr = '0; reg_data = '0; reg_ctrl = '0;
    #1;
    chk("rst_we", 32'(coeff_we), 32'd0);
    chk("rst_addr", 32'(coeff_addr), 32'd0);
    chk("rst_data", 32'(coeff_data), 32'd0);
    chk("rst_status", status, 32'd0);
    repeat (3) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (2) @(negedge user_clk);

    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rst) do_reset();
      n0 = n_wr;
      push_burst(vecs[v].addr, vecs[v].data, int'(vecs[v].len), vecs[v].ramp);
      trig(vecs[v].addr, vecs[v].data, vecs[v].len, vecs[v].ramp);
      wait_idle($sformatf("vec%0d", v), 400);
      chk($sformatf("vec%0d_writes", v), 32'(n_wr - n0), 32'(vecs[v].exp_wr));
      chk($sformatf("vec%0d_pending", v), 32'(exp_q.size()), 32'd0);
      chk($sformatf("vec%0d_done", v), 32'(status[1]), 32'd1);
      chk($sformatf("vec%0d_ovr", v), 32'(status[2]), 32'd0);
      chk($sformatf("vec%0d_zero", v), 32'(status[15:3]), 32'd0);
      chk($sformatf("vec%0d_count", v), 32'(status[31:16]), 32'(vecs[v].exp_cnt));
      release_trig();
    end

    // Overrun: second rising edge while a 256-word burst is in flight
    do_reset();
    n0 = n_wr;
    push_burst(10'h000, 32'h100, 255, 1'b1);
    trig(10'h000, 32'h100, 8'd255, 1'b1);
    repeat (20) @(negedge user_clk);
    reg_ctrl[0] = 1'b0;
    repeat (5) @(negedge user_clk);
    reg_ctrl[0] = 1'b1;
    wait_idle("ovr", 400);
    chk("ovr_writes", 32'(n_wr - n0), 32'd256);
    chk("ovr_set", 32'(status[2]), 32'd1);
    chk("ovr_done", 32'(status[1]), 32'd1);
    chk("ovr_pending", 32'(exp_q.size()), 32'd0);
    release_trig();
    push_burst(10'h020, 32'h1, 0, 1'b0);
    trig(10'h020, 32'h1, 8'd0, 1'b0);
    wait_idle("ovr_next", 50);
    chk("ovr_cleared", 32'(status[2]), 32'd0);
    release_trig();

    // Reset during the 10th write of a 100-word burst, trigger still high after
    do_reset();
    n0 = n_wr;
    push_burst(10'h010, 32'h55, 99, 1'b1);
    trig(10'h010, 32'h55, 8'd99, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge user_clk);
      #2;
      if (n_wr - n0 >= 10) break;
    end
    chk("mrst_at_10th", 32'(n_wr - n0), 32'd10);
    user_rst_n = 1'b0;
    #1;
    chk("mrst_we", 32'(coeff_we), 32'd0);
    chk("mrst_status", status, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge user_clk);
    user_rst_n = 1'b1;
    n1 = n_wr;
    repeat (30) @(negedge user_clk);
    chk("mrst_no_burst", 32'(n_wr - n1), 32'd0);
    chk("mrst_status_after", status, 32'd0);
    release_trig();

    // Latency and level hold: one burst for a long-held trigger
    do_reset();
    n0 = n_wr;
    first_we_cyc = -1;
    push_burst(10'h200, 32'h1234, 15, 1'b0);
    @(negedge user_clk);
    reg_addr = 32'h200; reg_data = 32'h1234; reg_ctrl = {16'h0, 8'd15, 8'h00};
    @(negedge user_clk);
    reg_ctrl[0] = 1'b1;
    c0 = cyc;
    repeat (1000) @(negedge user_clk);
    chk("hold_latency", 32'(first_we_cyc - c0), 32'd3);
    chk("hold_writes", 32'(n_wr - n0), 32'd16);
    chk("hold_pending", 32'(exp_q.size()), 32'd0);
    release_trig();

    // Write-counter saturation
    do_reset();
    for (int b = 0; b < 260; b++) begin
      push_burst(ADDR_W'(b), 32'(b), 255, 1'b1);
      trig(ADDR_W'(b), 32'(b), 8'd255, 1'b1);
      wait_idle("sat", 400);
      if (b == 254) chk("sat_pre", 32'(status[31:16]), 32'd65280);
      release_trig();
    end
    chk("sat_count", 32'(status[31:16]), 32'h0000FFFF);
    chk("sat_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quant_coeff_writer.md
QUANT_COEFF_WRITER -- requirements
Module: quant_coeff_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the coefficient RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the coefficient word width (DATA_W <= 32).
REQ-003 The block SHALL have port user_clk  input  1  as its single clock; all logic is rising-edge.
REQ-004 The block SHALL have port user_rst_n  input  1  as its reset, asynchronous and active-low.
REQ-005 The block SHALL have port reg_addr  input  32  as the software start address; bits [ADDR_W-1:0] are used.
REQ-006 The block SHALL have port reg_data  input  32  as the software coefficient word; bits [DATA_W-1:0] are used.
REQ-007 The block SHALL have port reg_ctrl  input  32  as the software control word: bit0 trigger, bit1 ramp enable, bits[15:8] burst length minus one.
REQ-008 The block SHALL have port coeff_we  output  1  as the coefficient RAM write enable.
REQ-009 The block SHALL have port coeff_addr  output  ADDR_W  as the coefficient RAM write address.
REQ-010 The block SHALL have port coeff_data  output  DATA_W  as the coefficient RAM write data.
REQ-011 The block SHALL have port status  output  32  for software readback: bit0 busy, bit1 done, bit2 overrun, bits[31:16] total-write count.

Function
REQ-012 reg_addr, reg_data and reg_ctrl come from another clock domain; the block SHALL resynchronise only reg_ctrl[0] through a 2-flop synchroniser plus one history flop.
- Software holds the other fields stable before raising bit0.
REQ-013 A trigger event SHALL be a rising edge on synchronised bit0, i.e. s2=1 and s3=0.
REQ-014 The FSM SHALL have states IDLE, WRITE and DONE.
- IDLE->WRITE on a trigger event.
- WRITE->DONE after the last write.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On IDLE->WRITE the block SHALL capture the following, clear done and overrun, and set busy:
- reg_addr[ADDR_W-1:0] into the address register.
- reg_data[DATA_W-1:0] into the data register.
- reg_ctrl[15:8] into the remaining-count register.
- reg_ctrl[1] into the ramp flag.
REQ-016 In WRITE the block SHALL assert coeff_we for exactly reg_ctrl[15:8]+1 consecutive cycles (1..256), one word per cycle.
REQ-017 After each write, coeff_addr SHALL increment by 1 modulo 2^ADDR_W, wrapping from 2^ADDR_W-1 to 0 without error.
REQ-018 With ramp set, coeff_data SHALL increment by 1 modulo 2^DATA_W after each write; with ramp clear it SHALL hold constant.
REQ-019 Latency: coeff_we SHALL first be high in the cycle after the 3rd user_clk rising edge that samples reg_ctrl[0] high.
REQ-020 coeff_we, coeff_addr and coeff_data SHALL be driven directly from registers.
REQ-021 In DONE the block SHALL clear busy and set done; done SHALL remain set until the next accepted trigger.
REQ-022 A trigger event in WRITE or DONE SHALL be ignored and SHALL set overrun (sticky); the burst in progress SHALL be unaffected.
REQ-023 status[31:16] SHALL count every cycle with coeff_we high and SHALL saturate at 0xFFFF.
REQ-024 status[15:3] SHALL read as 0.
REQ-025 Holding reg_ctrl[0] high SHALL produce only one burst; a new burst requires bit0 to go low and then high again.

Reset
REQ-026 While user_rst_n is low, the block SHALL asynchronously clear the following to 0 and set the state to IDLE:
- Synchroniser flops.
- coeff_we, coeff_addr and coeff_data.
- busy, done and overrun.
- The write counter.
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately, with no further coeff_we pulses.
REQ-028 After reset deasserts, a reg_ctrl[0] that is already high SHALL NOT be treated as a trigger until it has been seen low.
- Implementation: the history flop loads 1 on its first post-reset sample if bit0 is high.
REQ-029 Reset deassertion SHALL be synchronised externally; the block adds no reset synchroniser.

Structure
REQ-030 A shared package SHALL hold the following:
- The state enumeration (IDLE, WRITE, DONE).
- The status bit-position constants BUSY_BIT=0, DONE_BIT=1 and OVR_BIT=2.
- The control field constants TRIG_BIT=0, RAMP_BIT=1 and LEN_LSB=8 / LEN_MSB=15.
REQ-031 The block SHALL contain one sub-module, ctrl_edge_sync, which holds the 2-flop synchroniser and the edge detector.

Verification
REQ-032 Single write: reg_addr=0x05, reg_data=0xDEADBEEF, len=0, ramp=0, raise bit0 -> exactly one coeff_we cycle with addr 0x05 and data 0xDEADBEEF; done=1; count=1.
REQ-033 Ramp burst: addr=0x3FE, data=7, len=3, ramp=1 -> writes (0x3FE,7), (0x3FF,8), (0x000,9), (0x001,10) on consecutive cycles; count=4.
REQ-034 Overrun: a len=255 burst followed by a second bit0 rising edge during WRITE -> exactly 256 writes, overrun=1; the next accepted trigger clears overrun.
REQ-035 Mid-burst reset: assert user_rst_n=0 on the 10th write of a len=99 burst -> coeff_we=0 immediately, status=0; bit0 still high after reset -> no burst.
REQ-036 Latency and hold: bit0 held high for 1000 cycles -> exactly one burst, with the first coeff_we in the cycle after the 3rd sampling edge.
REQ-037 Counter saturation: 300 bursts of len=255 -> status[31:16] = 0xFFFF.
